// File: rtl/tm_controller.sv
// ============================================================================
//  Module      : tm_controller
//  Description : Turing-machine finite control. On every valid tape symbol it
//                looks up the rule for {cur_state, sym} in a run-time-loadable
//                rule table. It then drives the symbol to write and the head
//                direction back to the tape, and advances the machine state.
//                It also flags halt and undefined-rule faults and counts the
//                steps it has executed.
//                Optional feature macro: TM_STEP_LIMIT_EN (halt when
//                step_count reaches MAX_STEPS).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tm_controller #(
    parameter int STATE_BITS  = 4,
    parameter int SYM_BITS    = 3,
    parameter int START_STATE = 0,
    parameter int HALT_STATE  = 15,
    parameter int MAX_STEPS   = 1000
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            prog_we,
    input  logic [STATE_BITS+SYM_BITS-1:0]  prog_addr,
    input  logic [STATE_BITS+SYM_BITS+1:0]  prog_data,
    input  logic [SYM_BITS-1:0]             sym,
    input  logic                            sym_valid,
    output logic [SYM_BITS-1:0]             new_sym,
    output logic                            direction,
    output logic [STATE_BITS-1:0]           cur_state,
    output logic                            halted,
    output logic                            fault,
    output logic [15:0]                     step_count
);

    localparam int c_ADDR_W  = STATE_BITS + SYM_BITS;
    localparam int c_ENTRY_W = STATE_BITS + SYM_BITS + 2;
    localparam int c_DEPTH   = 1 << c_ADDR_W;

`ifdef TM_STEP_LIMIT_EN
    localparam bit c_LIMIT_EN = 1'b1;
`else
    localparam bit c_LIMIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } mode_t;

    mode_t                   r_mode;
    mode_t                   w_mode_next;

    logic [c_ENTRY_W-1:0]    r_table [0:c_DEPTH-1];
    logic [SYM_BITS-1:0]     r_new_sym;
    logic                    r_direction;
    logic [STATE_BITS-1:0]   r_cur_state;
    logic [15:0]             r_step_count;

    logic [c_ENTRY_W-1:0]    w_entry;
    logic                    w_e_valid;
    logic [STATE_BITS-1:0]   w_e_next;
    logic [SYM_BITS-1:0]     w_e_sym;
    logic                    w_e_dir;
    logic                    w_lookup;
    logic [15:0]             w_step_inc;
    logic                    w_limit_hit;

    // Asynchronous rule lookup and entry field decode {valid, next, sym, dir}
    assign w_entry     = r_table[{r_cur_state, sym}];
    assign w_e_valid   = w_entry[c_ENTRY_W-1];
    assign w_e_next    = w_entry[c_ENTRY_W-2 -: STATE_BITS];
    assign w_e_sym     = w_entry[SYM_BITS:1];
    assign w_e_dir     = w_entry[0];
    assign w_lookup    = (r_mode == RUN) && sym_valid;
    assign w_step_inc  = (r_step_count == 16'hFFFF) ? r_step_count : r_step_count + 16'd1;
    assign w_limit_hit = c_LIMIT_EN && (w_step_inc == 16'(MAX_STEPS));

    // Rule table write port; contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (prog_we && (r_mode == LOAD)) begin
            r_table[prog_addr] <= prog_data;
        end
    end

    // Mode register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mode <= LOAD;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    // Mode next-state logic; HALT and FAULT only exit through reset
    always_comb begin
        w_mode_next = r_mode;
        case (r_mode)
            LOAD: begin
                if (start) begin
                    w_mode_next = RUN;
                end
            end
            RUN: begin
                if (sym_valid) begin
                    if (!w_e_valid) begin
                        w_mode_next = FAULT;
                    end else if ((w_e_next == STATE_BITS'(HALT_STATE)) || w_limit_hit) begin
                        w_mode_next = HALT;
                    end
                end
            end
            default: w_mode_next = r_mode;
        endcase
    end

    // Datapath: tape outputs, machine state and step counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_new_sym    <= '0;
            r_direction  <= 1'b1;
            r_cur_state  <= STATE_BITS'(START_STATE);
            r_step_count <= 16'd0;
        end else begin
            if ((r_mode == LOAD) && start) begin
                r_cur_state  <= STATE_BITS'(START_STATE);
                r_step_count <= 16'd0;
            end
            if (sym_valid) begin
                if (w_lookup && w_e_valid) begin
                    r_new_sym    <= w_e_sym;
                    r_direction  <= w_e_dir;
                    r_cur_state  <= w_e_next;
                    r_step_count <= w_step_inc;
                end else begin
                    // Echo the symbol back so the tape's write is a no-op
                    r_new_sym <= sym;
                end
            end
        end
    end

    assign new_sym    = r_new_sym;
    assign direction  = r_direction;
    assign cur_state  = r_cur_state;
    assign step_count = r_step_count;
    assign halted     = (r_mode == HALT);
    assign fault      = (r_mode == FAULT);

endmodule

`default_nettype wire

// File: tb/tb_tm_controller.sv
// ============================================================================
//  Module      : tb_tm_controller
//  Description : Directed self-checking bench for tm_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tm_controller;

    logic        clock;
    logic        reset;
    logic        start;
    logic        prog_we;
    logic [6:0]  prog_addr;
    logic [8:0]  prog_data;
    logic [2:0]  sym;
    logic        sym_valid;
    logic [2:0]  new_sym;
    logic        direction;
    logic [3:0]  cur_state;
    logic        halted;
    logic        fault;
    logic [15:0] step_count;

    int n_checks = 0;
    int n_errors = 0;

    tm_controller #(
        .STATE_BITS  (4),
        .SYM_BITS    (3),
        .START_STATE (0),
        .HALT_STATE  (15),
        .MAX_STEPS   (4)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .sym        (sym),
        .sym_valid  (sym_valid),
        .new_sym    (new_sym),
        .direction  (direction),
        .cur_state  (cur_state),
        .halted     (halted),
        .fault      (fault),
        .step_count (step_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Rule entry {valid, next_state, new_sym, dir}
    function automatic logic [8:0] rule(input logic v, input logic [3:0] ns,
                                        input logic [2:0] s, input logic d);
        return {v, ns, s, d};
    endfunction

    task automatic write_rule(input logic [6:0] a, input logic [8:0] d, input logic st);
        prog_addr = a;
        prog_data = d;
        prog_we   = 1'b1;
        start     = st;
        tick();
        prog_we   = 1'b0;
        start     = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One tape transaction: sym_valid, then the tape's write and move cycles
    task automatic present(input logic [2:0] s);
        sym       = s;
        sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Busy beaver hand trace: symbols seen, resulting state, written dir
    logic [2:0] bb_sym [6] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd1};
    logic [3:0] bb_st  [6] = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd15};
    logic       bb_dir [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0;
        prog_data = '0; sym = '0; sym_valid = 1'b0;
        #2;
        check("rst_new_sym",   32'(new_sym),    32'd0);
        check("rst_direction", 32'(direction),  32'd1);
        check("rst_cur_state", 32'(cur_state),  32'd0);
        check("rst_halted",    32'(halted),     32'd0);
        check("rst_fault",     32'(fault),      32'd0);
        check("rst_steps",     32'(step_count), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Symbol echo while in LOAD
        present(3'd5);
        check("load_echo_sym", 32'(new_sym),    32'd5);
        check("load_echo_dir", 32'(direction),  32'd1);
        check("load_echo_stp", 32'(step_count), 32'd0);

        // Busy beaver program; last write coincides with start
        write_rule(7'd3, 9'd0, 1'b0);
        write_rule(7'd0, rule(1, 4'd1,  3'd1, 1'b1), 1'b0);
        write_rule(7'd1, rule(1, 4'd1,  3'd1, 1'b0), 1'b0);
        write_rule(7'd8, rule(1, 4'd0,  3'd1, 1'b0), 1'b0);
        write_rule(7'd9, rule(1, 4'd15, 3'd1, 1'b1), 1'b1);
        for (int i = 0; i < 6; i++) begin
            present(bb_sym[i]);
            check($sformatf("bb_state%0d", i), 32'(cur_state), 32'(bb_st[i]));
            check($sformatf("bb_dir%0d", i),   32'(direction), 32'(bb_dir[i]));
            check($sformatf("bb_sym%0d", i),   32'(new_sym),   32'd1);
        end
        check("bb_halted", 32'(halted),     32'd1);
        check("bb_steps",  32'(step_count), 32'd6);
        check("bb_fault",  32'(fault),      32'd0);
        present(3'd6);
        check("halt_echo",   32'(new_sym),    32'd6);
        check("halt_sticky", 32'(halted),     32'd1);
        check("halt_steps",  32'(step_count), 32'd6);

        // Write during RUN must be ignored; then reset mid-transaction
        do_reset();
        pulse_start();
        write_rule(7'd0, 9'd0, 1'b0);
        present(3'd0);
        check("run_we_ignored", 32'(cur_state), 32'd1);
        check("run_we_fault",   32'(fault),     32'd0);
        sym = 3'd0; sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        check("pre_abort_state", 32'(cur_state), 32'd0);
        #3 reset = 1'b1;
        #1;
        check("abort_new_sym", 32'(new_sym),    32'd0);
        check("abort_dir",     32'(direction),  32'd1);
        check("abort_state",   32'(cur_state),  32'd0);
        check("abort_steps",   32'(step_count), 32'd0);
        check("abort_halted",  32'(halted),     32'd0);
        tick();
        reset = 1'b0;
        tick();
        pulse_start();
        for (int i = 0; i < 6; i++) present(bb_sym[i]);
        check("rerun_halted", 32'(halted),     32'd1);
        check("rerun_steps",  32'(step_count), 32'd6);
        check("rerun_state",  32'(cur_state),  32'd15);

        // Invalid rule -> sticky FAULT
        do_reset();
        pulse_start();
        present(3'd3);
        check("flt_fault",   32'(fault),      32'd1);
        check("flt_new_sym", 32'(new_sym),    32'd3);
        check("flt_state",   32'(cur_state),  32'd0);
        check("flt_dir",     32'(direction),  32'd1);
        check("flt_steps",   32'(step_count), 32'd0);
        check("flt_halted",  32'(halted),     32'd0);
        for (int i = 0; i < 10; i++) begin
            present(3'(i));
            check($sformatf("flt_sticky%0d", i), 32'(fault), 32'd1);
        end
        check("flt_state_end", 32'(cur_state), 32'd0);

        // Two-state cycling machine, no halt rule
        do_reset();
        write_rule(7'd0, rule(1, 4'd1, 3'd0, 1'b1), 1'b0);
        write_rule(7'd8, rule(1, 4'd0, 3'd0, 1'b1), 1'b1);
        for (int i = 0; i < 3; i++) present(3'd0);
        check("cyc3_halted", 32'(halted),     32'd0);
        check("cyc3_steps",  32'(step_count), 32'd3);
        present(3'd0);
        check("cyc4_steps",  32'(step_count), 32'd4);
        check("cyc4_state",  32'(cur_state),  32'd0);
`ifdef TM_STEP_LIMIT_EN
        check("cyc4_halted", 32'(halted), 32'd1);
        present(3'd0);
        check("cyc5_steps",  32'(step_count), 32'd4);
`else
        check("cyc4_halted", 32'(halted), 32'd0);
        present(3'd0);
        check("cyc5_steps",  32'(step_count), 32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
